// File: rtl/alu_seq_pkg.sv
// Shared constants and FSM encoding for the ALU command sequencer.
package alu_seq_pkg;
  localparam int DATA_W_D = 8;
  localparam int OP_W_D   = 3;
  localparam int ADDR_W_D = 3;
  localparam int CNT_W_D  = 4;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} seq_state_t;
endpackage

// File: rtl/alu_seq_regfile.sv
// Local operand register file: one sync write port, three async read ports, sync clear.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_ra_addr,
  output logic [DATA_W-1:0] o_ra_data,
  input  logic [ADDR_W-1:0] i_rb_addr,
  output logic [DATA_W-1:0] o_rb_data,
  input  logic [ADDR_W-1:0] i_rh_addr,
  output logic [DATA_W-1:0] o_rh_data
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_ra_data = r_mem[i_ra_addr];
  assign o_rb_data = r_mem[i_rb_addr];
  assign o_rh_data = r_mem[i_rh_addr];
endmodule

// File: rtl/alu_sequencer.sv
// Command-driven initiator for the registered ALU: snapshot operands, issue,
// wait out the ALU latency, chain repeats, write back the final result.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W      = DATA_W_D,
  parameter int OP_W        = OP_W_D,
  parameter int ADDR_W      = ADDR_W_D,
  parameter int CNT_W       = CNT_W_D,
  parameter int ALU_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_cmd_valid,
  output logic              out_cmd_ready,
  input  logic [OP_W-1:0]   in_cmd_op,
  input  logic [ADDR_W-1:0] in_cmd_src_a,
  input  logic [ADDR_W-1:0] in_cmd_src_b,
  input  logic [ADDR_W-1:0] in_cmd_dst,
  input  logic [CNT_W-1:0]  in_cmd_count,
  input  logic              in_wr_en,
  input  logic [ADDR_W-1:0] in_wr_addr,
  input  logic [DATA_W-1:0] in_wr_data,
  input  logic [ADDR_W-1:0] in_rd_addr,
  output logic [DATA_W-1:0] out_rd_data,
  output logic [DATA_W-1:0] out_alu_a,
  output logic [DATA_W-1:0] out_alu_b,
  output logic [OP_W-1:0]   out_alu_op,
  input  logic [DATA_W-1:0] in_alu_data,
  output logic              out_busy,
  output logic              out_done,
  output logic              out_zero
);
  // WAIT counts 0..ALU_LATENCY-2; width kept at least one bit for latency 1.
  localparam int WCW = (ALU_LATENCY > 2) ? $clog2(ALU_LATENCY - 1) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'((ALU_LATENCY > 1) ? ALU_LATENCY - 2 : 0);

  seq_state_t        r_state, w_next;
  logic [DATA_W-1:0] r_a, r_b;
  logic [OP_W-1:0]   r_op;
  logic [ADDR_W-1:0] r_dst;
  logic [CNT_W-1:0]  r_rem;
  logic [WCW-1:0]    r_wcnt;
  logic              r_done, r_zero;

  logic              w_accept, w_last, w_wb_wr, w_host_wr, w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata, w_snap_a, w_snap_b;

  assign out_cmd_ready = (r_state == IDLE) && !rst;
  assign out_busy      = (r_state != IDLE);
  assign w_accept      = in_cmd_valid && out_cmd_ready;
  assign w_last        = (r_rem == CNT_W'(1));

  // Only the final pass of a chain reaches the register file; host writes
  // are locked out for the whole command, so the two never collide.
  assign w_wb_wr   = (r_state == WB) && w_last;
  assign w_host_wr = in_wr_en && !out_busy;
  assign w_we      = w_wb_wr || w_host_wr;
  assign w_waddr   = w_wb_wr ? r_dst : in_wr_addr;
  assign w_wdata   = w_wb_wr ? in_alu_data : in_wr_data;

  alu_seq_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_ra_addr (in_cmd_src_a),
    .o_ra_data (w_snap_a),
    .i_rb_addr (in_cmd_src_b),
    .o_rb_data (w_snap_b),
    .i_rh_addr (in_rd_addr),
    .o_rh_data (out_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = ISSUE;
      ISSUE:   w_next = (ALU_LATENCY > 1) ? WAIT : WB;
      WAIT:    if (r_wcnt == WAIT_LAST) w_next = WB;
      WB:      w_next = w_last ? IDLE : ISSUE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_dst  <= '0;
      r_rem  <= '0;
      r_wcnt <= '0;
      r_done <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a   <= w_snap_a;
        r_b   <= w_snap_b;
        r_op  <= in_cmd_op;
        r_dst <= in_cmd_dst;
        r_rem <= (in_cmd_count == '0) ? CNT_W'(1) : in_cmd_count;
      end
      if (r_state == ISSUE)     r_wcnt <= '0;
      else if (r_state == WAIT) r_wcnt <= r_wcnt + 1'b1;
      if (r_state == WB) begin
        if (!w_last) begin
          r_a   <= in_alu_data;
          r_rem <= r_rem - 1'b1;
        end else begin
          r_zero <= (in_alu_data == '0);
          r_done <= 1'b1;
        end
      end
    end
  end

  assign out_alu_a  = r_a;
  assign out_alu_b  = r_b;
  assign out_alu_op = r_op;
  assign out_done   = r_done;
  assign out_zero   = r_zero;
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: transaction-level model compared every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb_alu_sequencer;
  import alu_seq_pkg::*;
  localparam int L = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_cmd_valid = 1'b0;
  logic       out_cmd_ready;
  logic [2:0] in_cmd_op = '0, in_cmd_src_a = '0, in_cmd_src_b = '0, in_cmd_dst = '0;
  logic [3:0] in_cmd_count = '0;
  logic       in_wr_en = 1'b0;
  logic [2:0] in_wr_addr = '0;
  logic [7:0] in_wr_data = '0;
  logic [2:0] in_rd_addr = '0;
  logic [7:0] out_rd_data, out_alu_a, out_alu_b, in_alu_data;
  logic [2:0] out_alu_op;
  logic       out_busy, out_done, out_zero;

  alu_sequencer #(.ALU_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .in_cmd_valid(in_cmd_valid), .out_cmd_ready(out_cmd_ready),
    .in_cmd_op(in_cmd_op), .in_cmd_src_a(in_cmd_src_a), .in_cmd_src_b(in_cmd_src_b),
    .in_cmd_dst(in_cmd_dst), .in_cmd_count(in_cmd_count),
    .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr), .in_wr_data(in_wr_data),
    .in_rd_addr(in_rd_addr), .out_rd_data(out_rd_data),
    .out_alu_a(out_alu_a), .out_alu_b(out_alu_b), .out_alu_op(out_alu_op),
    .in_alu_data(in_alu_data),
    .out_busy(out_busy), .out_done(out_done), .out_zero(out_zero)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return ~a;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return a & b;
      3'd6: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Stand-in for the registered ALU (latency 1).
  always @(posedge clk) in_alu_data <= alu_f(out_alu_a, out_alu_b, out_alu_op);

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Model: a command occupies n*(L+1) cycles; chain results precomputed on accept.
  logic [7:0] m_regs [8];
  logic [7:0] m_chain [17];
  logic [7:0] m_a = '0, m_b = '0;
  logic [2:0] m_op = '0, m_dst = '0;
  bit         m_busy = 0, m_done = 0, m_zero = 0, m_on = 0;
  int         m_el = 0, m_n = 0;

  initial forever begin
    @(posedge clk);
    m_on = 1;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_busy = 0; m_done = 0; m_zero = 0; m_a = '0; m_b = '0; m_op = '0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_el++;
        if (m_el % (L + 1) == 0) begin
          if (m_el / (L + 1) == m_n) begin
            m_regs[m_dst] = m_chain[m_n];
            m_zero = (m_chain[m_n] == 8'h00);
            m_done = 1;
            m_busy = 0;
          end else begin
            m_a = m_chain[m_el / (L + 1)];
          end
        end
      end else begin
        if (in_cmd_valid) begin
          m_n = (in_cmd_count == 0) ? 1 : int'(in_cmd_count);
          m_chain[0] = m_regs[in_cmd_src_a];
          m_b = m_regs[in_cmd_src_b];
          m_op = in_cmd_op;
          m_dst = in_cmd_dst;
          for (int k = 0; k < m_n; k++) m_chain[k+1] = alu_f(m_chain[k], m_b, m_op);
          m_a = m_chain[0];
          m_busy = 1;
          m_el = 0;
        end
        if (in_wr_en) m_regs[in_wr_addr] = in_wr_data;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_on) begin
      chk("ready", out_cmd_ready, !rst && !m_busy);
      chk("busy", out_busy, m_busy);
      chk("done", out_done, m_done);
      chk("zero", out_zero, m_zero);
      chk("rd_data", out_rd_data, m_regs[in_rd_addr]);
      chk("alu_a", out_alu_a, m_a);
      chk("alu_b", out_alu_b, m_b);
      chk("alu_op", out_alu_op, m_op);
    end
  end

  logic [7:0] t_aseq [16];
  logic [7:0] t_b1, t_pre_rd;
  logic [2:0] t_op1;

  task automatic tick; @(posedge clk); #1; endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    tick; in_wr_en = 1; in_wr_addr = a; in_wr_data = d;
    tick; in_wr_en = 0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e, input string nm);
    tick; in_rd_addr = a;
    @(negedge clk); chk(nm, out_rd_data, e);
  endtask

  task automatic wait_ready;
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_cmd_ready) begin ok = 1; break; end
    end
    if (!ok) begin n_chk++; $display("FAIL ready_timeout: ready never rose within 50 cycles"); end
  endtask

  // lat = index of the done cycle, counting the first negedge after entry as 1.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) begin t_b1 = out_alu_b; t_op1 = out_alu_op; end
      if ((i - 1) % (L + 1) == 0 && (i - 1) / (L + 1) < 16) t_aseq[(i - 1) / (L + 1)] = out_alu_a;
      if (out_done) begin lat = i; break; end
      t_pre_rd = out_rd_data;
    end
    if (lat < 0) begin n_chk++; $display("FAIL done_timeout: no done within 60 cycles, required one"); end
  endtask

  task automatic cmd(input logic [2:0] op, input logic [2:0] sa, input logic [2:0] sb,
                     input logic [2:0] d, input logic [3:0] cnt, output int lat);
    tick;
    in_cmd_op = op; in_cmd_src_a = sa; in_cmd_src_b = sb; in_cmd_dst = d;
    in_cmd_count = cnt; in_cmd_valid = 1; in_rd_addr = d;
    wait_ready;
    tick; in_cmd_valid = 0;
    wait_done(lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // 1. reset
    tick;
    @(negedge clk);
    chk("rst_ready", out_cmd_ready, 1'b0);
    chk("rst_busy", out_busy, 1'b0);
    tick; rst = 0;
    @(negedge clk);
    chk("post_rst_ready", out_cmd_ready, 1'b1);
    chk("post_rst_done", out_done, 1'b0);
    for (int i = 0; i < 8; i++) rd(3'(i), 8'h00, "rst_reg");

    // 2. single ADD
    wr(3'd1, 8'h05); wr(3'd2, 8'h04);
    cmd(OP_ADD, 3'd1, 3'd2, 3'd3, 4'd1, lat);
    chk("add_lat", lat, 3);
    chk("add_issue_a", t_aseq[0], 8'h05);
    chk("add_issue_b", t_b1, 8'h04);
    chk("add_issue_op", t_op1, 3'd0);
    chk("add_r3", out_rd_data, 8'h09);
    chk("add_zero", out_zero, 1'b0);

    // 3. chained ADD x3
    cmd(OP_ADD, 3'd1, 3'd2, 3'd4, 4'd3, lat);
    chk("chain_lat", lat, 7);
    chk("chain_a0", t_aseq[0], 8'h05);
    chk("chain_a1", t_aseq[1], 8'h09);
    chk("chain_a2", t_aseq[2], 8'h0D);
    chk("chain_pre_rd", t_pre_rd, 8'h00);
    chk("chain_r4", out_rd_data, 8'h11);

    // 4. wrap to zero, NAND, NOT with count 0
    wr(3'd1, 8'hFF); wr(3'd2, 8'h01);
    cmd(OP_ADD, 3'd1, 3'd2, 3'd3, 4'd1, lat);
    chk("wrap_r3", out_rd_data, 8'h00);
    chk("wrap_zero", out_zero, 1'b1);
    wr(3'd1, 8'hF0); wr(3'd2, 8'h3C);
    cmd(OP_NAND, 3'd1, 3'd2, 3'd3, 4'd1, lat);
    chk("nand_r3", out_rd_data, 8'hCF);
    chk("nand_zero", out_zero, 1'b0);
    cmd(OP_NOT, 3'd1, 3'd2, 3'd5, 4'd0, lat);
    chk("not_cnt0_lat", lat, 3);
    chk("not_r5", out_rd_data, 8'h0F);

    // 5. valid held while busy, back-to-back accept, host write while busy
    wr(3'd1, 8'h05); wr(3'd2, 8'h04);
    tick;
    in_cmd_op = OP_ADD; in_cmd_src_a = 3'd1; in_cmd_src_b = 3'd2; in_cmd_dst = 3'd6;
    in_cmd_count = 4'd2; in_cmd_valid = 1; in_rd_addr = 3'd6;
    wait_ready;
    tick;
    in_cmd_op = OP_SUB; in_cmd_src_a = 3'd6; in_cmd_src_b = 3'd2; in_cmd_dst = 3'd7;
    in_cmd_count = 4'd1;
    in_wr_en = 1; in_wr_addr = 3'd2; in_wr_data = 8'hAA;
    tick; in_wr_en = 0;
    wait_done(lat);
    chk("b2b_first_lat", lat, 4);
    chk("b2b_r6", out_rd_data, 8'h0D);
    chk("b2b_ready_in_done", out_cmd_ready, 1'b1);
    tick; in_cmd_valid = 0; in_rd_addr = 3'd7;
    @(negedge clk);
    chk("b2b_busy_after", out_busy, 1'b1);
    wait_done(lat);
    chk("b2b_second_lat", lat, 2);
    chk("b2b_r7", out_rd_data, 8'h09);
    rd(3'd2, 8'h04, "busy_wr_ignored");

    // same-cycle host write and accept: snapshot sees the old r1
    tick;
    in_cmd_op = OP_ADD; in_cmd_src_a = 3'd1; in_cmd_src_b = 3'd1; in_cmd_dst = 3'd0;
    in_cmd_count = 4'd1; in_cmd_valid = 1; in_rd_addr = 3'd0;
    in_wr_en = 1; in_wr_addr = 3'd1; in_wr_data = 8'h20;
    tick; in_cmd_valid = 0; in_wr_en = 0;
    wait_done(lat);
    chk("snap_lat", lat, 3);
    chk("snap_r0", out_rd_data, 8'h0A);
    rd(3'd1, 8'h20, "snap_wr_landed");

    // 6. reset in the second WB of a 3-op chain
    tick;
    in_cmd_op = OP_ADD; in_cmd_src_a = 3'd1; in_cmd_src_b = 3'd2; in_cmd_dst = 3'd3;
    in_cmd_count = 4'd3; in_cmd_valid = 1; in_rd_addr = 3'd3;
    wait_ready;
    tick; in_cmd_valid = 0;
    tick; tick; tick; rst = 1;
    @(negedge clk);
    chk("midrst_busy", out_busy, 1'b1);
    tick; rst = 0;
    @(negedge clk);
    chk("midrst_ready", out_cmd_ready, 1'b1);
    chk("midrst_busy_clr", out_busy, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_nodone", out_done, 1'b0);
    end
    for (int i = 0; i < 8; i++) rd(3'(i), 8'h00, "midrst_reg");

    tick;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
